dcache_victim_sel: RTL and testbench
====================================

Name: dcache_victim_sel

Overview:
- Replacement-policy controller for the data cache. Sits directly upstream of dcache_lru_altram and is its only client.
- Each set stores one LOG2_WAYS-bit next-victim pointer. This block:
  - initialises all pointers after reset;
  - answers victim queries from the miss path;
  - applies hit touches from the lookup path.
- Pipelined read-modify-write: one request per cycle, no stalls. Back-to-back same-set correctness relies on dcache_lru_altram forwarding last-cycle write data when read and write addresses collide.

Parameters:
- LOG2_WAYS, 3, log2 of associativity; pointer width.
- INDEX_BITS, 8, set index width; NUM_ENTRIES = 2**INDEX_BITS.

Ports:
- clock  in  1  single clock; all state on posedge.
- aclr  in  1  reset; synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_op  in  1  0 = touch (hit update), 1 = victim query.
- req_index  in  INDEX_BITS  set index.
- req_way  in  LOG2_WAYS  way that hit (touch only; ignored for victim).
- resp_valid  out  1  victim result valid (one-cycle pulse).
- resp_way  out  LOG2_WAYS  victim way.
- init_done  out  1  pointer sweep complete.
- ram_rden  out  1  to LRU RAM rden.
- ram_rdaddress  out  INDEX_BITS  to LRU RAM rdaddress.
- ram_q  in  LOG2_WAYS  from LRU RAM q; valid one cycle after ram_rden.
- ram_wren  out  1  to LRU RAM wren.
- ram_wraddress  out  INDEX_BITS  to LRU RAM wraddress.
- ram_data  out  LOG2_WAYS  to LRU RAM data.

Behaviour:
- Reset and init:
  - States: INIT, RUN.
  - aclr forces INIT, sweep counter = 0, stage-1 valid = 0. Registered outputs reset to 0: init_done = 0, resp_valid = 0, resp_way = 0.
  - INIT, every cycle after aclr deasserts: ram_wren = 1, ram_wraddress = counter, ram_data = 0, ram_rden = 0; counter increments.
  - Write of NUM_ENTRIES-1 goes to RUN; init_done = 1 from the next cycle.
  - Sweep takes exactly NUM_ENTRIES cycles.
- req_ready = init_done && !aclr. Combinational; no other backpressure.
- Stage 0 (acceptance cycle t):
  - ram_rden = 1, ram_rdaddress = req_index, both combinational from the request.
  - Register op, index and way into stage 1 with valid = 1.
  - ram_rdaddress = req_index even when idle.
- Stage 1 (cycle t+1): p = ram_q.
  - Victim op: resp_valid = 1, resp_way = p. Write pointer p+1 (mod 2**LOG2_WAYS, natural wrap) to the same index.
  - Touch op, req_way == p: write p+1.
  - Touch op, req_way != p: no write (ram_wren = 0).
  - In RUN, ram_wren, ram_wraddress and ram_data come from stage 1 only.
- Outputs are combinational from stage-1 registers and ram_q. resp_valid is never asserted for touches.
- Simultaneous stage-1 write and stage-0 read to the same index: no stall. The RAM returns the written value next cycle, so consecutive ops to one set see the updated pointer.
- aclr mid-operation:
  - Stage 1 is squashed: no resp_valid, no write from the squashed op.
  - The sweep restarts from 0 regardless of prior progress.
- An op in stage 1 during the cycle aclr is asserted is also squashed.
- Requests presented while req_ready = 0 are ignored, not queued.

Test Plan (LOG2_WAYS=3, INDEX_BITS=4):
- Init sweep: pulse aclr 1 cycle → ram_wren = 1 with ram_wraddress 0..15, ram_data = 0, over 16 consecutive cycles. req_ready = 0 throughout; init_done = 1 on the cycle after address 15.
- Victim sequence: 9 victim ops to index 5, spaced 2 cycles apart → resp_way 0,1,2,3,4,5,6,7,0, each 1 cycle after acceptance. Write data 1,2,…,7,0,1.
- Back-to-back: victim ops to index 3 on 3 consecutive cycles → resp_way 0,1,2 on consecutive cycles (exercises RAM collision forwarding).
- Touch rules, index 7 with pointer = 2:
  - touch way 2 → write 3, no resp_valid;
  - then touch way 6 → ram_wren stays 0;
  - then victim → resp_way = 3.
- Reset mid-op: accept victim to index 9 (pointer 4), assert aclr next cycle → no resp_valid, no write to 9. Sweep restarts at 0; after init, victim to 9 → resp_way = 0.
- Interleave: consecutive victims to indices 1,2,1 from fresh init → resp_way 0,0,1; final pointers idx1 = 2, idx2 = 1.

Source files
------------

// File: rtl/dcache_victim_sel.sv
// dcache_victim_sel
//
// Round-robin replacement controller for the data cache. It owns the
// next-victim pointer array held in dcache_lru_altram. It clears every
// pointer after reset, answers victim queries from the miss path, and
// advances a pointer when a hit touches the way it currently names.
//
// The block is a two-stage read-modify-write pipeline. It accepts one
// request per cycle and never stalls.
//   stage 0 : issue the RAM read for the request index
//   stage 1 : use the returned pointer, answer or update it
// Back-to-back operations on one set depend on the RAM returning the word
// written in the same cycle when its read and write addresses collide.
//
// Ports
//   clock, aclr               clock; synchronous active-high reset
//   req_valid/req_ready       request handshake (ready is combinational)
//   req_op                    0 = touch (hit update), 1 = victim query
//   req_index, req_way        set index; hit way (touch only)
//   resp_valid, resp_way      victim answer, one cycle after acceptance
//   init_done                 pointer sweep finished
//   ram_rden, ram_rdaddress   LRU RAM read port
//   ram_q                     LRU RAM read data, one cycle after ram_rden
//   ram_wren, ram_wraddress,
//   ram_data                  LRU RAM write port
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_INIT | sweeping zeros into every pointer; requests not accepted
// ST_RUN  | normal operation; RAM writes come from stage 1 only

module dcache_victim_sel #(
  parameter int LOG2_WAYS  = 3,
  parameter int INDEX_BITS = 8
) (
  input  logic                  clock,
  input  logic                  aclr,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_op,
  input  logic [INDEX_BITS-1:0] req_index,
  input  logic [LOG2_WAYS-1:0]  req_way,
  output logic                  resp_valid,
  output logic [LOG2_WAYS-1:0]  resp_way,
  output logic                  init_done,
  output logic                  ram_rden,
  output logic [INDEX_BITS-1:0] ram_rdaddress,
  input  logic [LOG2_WAYS-1:0]  ram_q,
  output logic                  ram_wren,
  output logic [INDEX_BITS-1:0] ram_wraddress,
  output logic [LOG2_WAYS-1:0]  ram_data
);

  localparam logic [INDEX_BITS-1:0] LAST_INDEX = '1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [INDEX_BITS-1:0]  sweep_cnt_q, sweep_cnt_d;
  logic                   init_done_d;

  logic                   s1_valid_q;
  logic                   s1_op_q;
  logic [INDEX_BITS-1:0]  s1_index_q;
  logic [LOG2_WAYS-1:0]   s1_way_q;

  logic                   accept;
  logic                   s1_live;
  logic [LOG2_WAYS-1:0]   ptr_next;

  assign req_ready     = init_done && !aclr;
  assign accept        = req_valid && req_ready;
  assign ram_rden      = accept;
  assign ram_rdaddress = req_index;

  // An op sitting in stage 1 while reset is asserted must neither answer
  // nor write, so stage 1 is qualified with aclr combinationally.
  assign s1_live  = s1_valid_q && !aclr;
  assign ptr_next = ram_q + 1'b1;

  always_ff @(posedge clock) begin
    if (aclr) begin
      state_q     <= ST_INIT;
      sweep_cnt_q <= '0;
      init_done   <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_op_q     <= 1'b0;
      s1_index_q  <= '0;
      s1_way_q    <= '0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
      init_done   <= init_done_d;
      s1_valid_q  <= accept;
      if (accept) begin
        s1_op_q    <= req_op;
        s1_index_q <= req_index;
        s1_way_q   <= req_way;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    sweep_cnt_d   = sweep_cnt_q;
    init_done_d   = init_done;
    ram_wren      = 1'b0;
    ram_wraddress = s1_index_q;
    ram_data      = ptr_next;
    resp_valid    = 1'b0;
    resp_way      = '0;

    if (s1_live && s1_op_q) begin
      resp_valid = 1'b1;
      resp_way   = ram_q;
    end

    case (state_q)
      ST_INIT: begin
        if (!aclr) begin
          ram_wren      = 1'b1;
          ram_wraddress = sweep_cnt_q;
          ram_data      = '0;
          sweep_cnt_d   = sweep_cnt_q + 1'b1;
          if (sweep_cnt_q == LAST_INDEX) begin
            state_d     = ST_RUN;
            init_done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        // Victims always advance the pointer. A touch advances it only
        // when the hit way is the one the pointer would evict next.
        ram_wren = s1_live && (s1_op_q || (s1_way_q == ram_q));
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_victim_sel.sv
module tb_dcache_victim_sel;

  localparam int LW = 3;
  localparam int IB = 4;
  localparam int N  = 16;

  logic          clock = 1'b0;
  logic          aclr = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_op = 1'b0;
  logic [IB-1:0] req_index = '0;
  logic [LW-1:0] req_way = '0;
  logic          resp_valid;
  logic [LW-1:0] resp_way;
  logic          init_done;
  logic          ram_rden;
  logic [IB-1:0] ram_rdaddress;
  logic [LW-1:0] ram_q = '0;
  logic          ram_wren;
  logic [IB-1:0] ram_wraddress;
  logic [LW-1:0] ram_data;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  dcache_victim_sel #(.LOG2_WAYS(LW), .INDEX_BITS(IB)) dut (
    .clock(clock), .aclr(aclr),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_index(req_index), .req_way(req_way),
    .resp_valid(resp_valid), .resp_way(resp_way), .init_done(init_done),
    .ram_rden(ram_rden), .ram_rdaddress(ram_rdaddress), .ram_q(ram_q),
    .ram_wren(ram_wren), .ram_wraddress(ram_wraddress), .ram_data(ram_data)
  );

  // LRU RAM stand-in: registered read, new data returned on a collision.
  logic [LW-1:0] mem [N];
  initial for (int i = 0; i < N; i++) mem[i] = LW'($urandom_range(0, 7));
  always @(posedge clock) begin
    if (ram_wren) mem[ram_wraddress] <= ram_data;
    if (ram_rden)
      ram_q <= (ram_wren && ram_wraddress == ram_rdaddress) ? ram_data : mem[ram_rdaddress];
  end

  typedef struct {
    bit op;
    int index;
    int way;
    bit exp_rv;
    int exp_way;
    bit exp_wren;
    int exp_data;
  } vec_t;
  vec_t vecs[$];

  int model_ptr [N];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic set_req(input bit v, input bit op, input int idx, input int way);
    req_valid = v;
    req_op    = op;
    req_index = IB'(idx);
    req_way   = LW'(way);
  endtask

  // aclr already released by the caller's previous cycle or held now;
  // runs the 16 sweep cycles plus the first RUN cycle.
  task automatic sweep_check(input string tag);
    for (int i = 0; i < N; i++) begin
      next_cycle();
      aclr = 1'b0;
      set_req(1, 1, 0, 0);
      mid();
      check($sformatf("%s sweep wren %0d", tag, i), int'(ram_wren), 1);
      check($sformatf("%s sweep addr %0d", tag, i), int'(ram_wraddress), i);
      check($sformatf("%s sweep data %0d", tag, i), int'(ram_data), 0);
      check($sformatf("%s sweep ready %0d", tag, i), int'(req_ready), 0);
      check($sformatf("%s sweep rden %0d", tag, i), int'(ram_rden), 0);
      check($sformatf("%s sweep init_done %0d", tag, i), int'(init_done), 0);
    end
    next_cycle();
    set_req(0, 0, 0, 0);
    mid();
    check({tag, " init_done after sweep"}, int'(init_done), 1);
    check({tag, " ready after sweep"}, int'(req_ready), 1);
    for (int i = 0; i < N; i++) model_ptr[i] = 0;
  endtask

  task automatic reset_and_init(input string tag);
    next_cycle();
    set_req(0, 0, 0, 0);
    aclr = 1'b1;
    mid();
    sweep_check(tag);
  endtask

  task automatic vec_apply(input vec_t v, input string tag);
    next_cycle();
    set_req(1, v.op, v.index, v.way);
    mid();
    check({tag, " rden"}, int'(ram_rden), 1);
    check({tag, " rdaddress"}, int'(ram_rdaddress), v.index);
    next_cycle();
    set_req(0, 0, 0, 0);
    mid();
    check({tag, " resp_valid"}, int'(resp_valid), int'(v.exp_rv));
    if (v.exp_rv) check({tag, " resp_way"}, int'(resp_way), v.exp_way);
    check({tag, " wren"}, int'(ram_wren), int'(v.exp_wren));
    if (v.exp_wren) begin
      check({tag, " wraddress"}, int'(ram_wraddress), v.index);
      check({tag, " data"}, int'(ram_data), v.exp_data);
    end
  endtask

  initial begin
    // Directed table, all from a freshly cleared pointer array.
    for (int k = 0; k < 9; k++)
      vecs.push_back('{1, 5, 0, 1, k % 8, 1, (k + 1) % 8});
    vecs.push_back('{1, 7, 0, 1, 0, 1, 1});
    vecs.push_back('{1, 7, 0, 1, 1, 1, 2});
    vecs.push_back('{0, 7, 2, 0, 0, 1, 3});   // touch matches pointer 2
    vecs.push_back('{0, 7, 6, 0, 0, 0, 0});   // touch misses pointer 3
    vecs.push_back('{1, 7, 0, 1, 3, 1, 4});
    vecs.push_back('{0, 7, 4, 0, 0, 1, 5});
    vecs.push_back('{0, 7, 5, 0, 0, 1, 6});
    vecs.push_back('{1, 7, 0, 1, 6, 1, 7});
    vecs.push_back('{0, 7, 7, 0, 0, 1, 0});   // touch wraps 7 -> 0
    vecs.push_back('{1, 7, 0, 1, 0, 1, 1});
    vecs.push_back('{0, 12, 0, 0, 0, 1, 1});
    vecs.push_back('{0, 12, 0, 0, 0, 0, 0});
    for (int k = 0; k < 4; k++)
      vecs.push_back('{1, 9, 0, 1, k, 1, k + 1});

    // Reset state: aclr held over a clock edge.
    next_cycle();
    aclr = 1'b1;
    mid();
    next_cycle();
    mid();
    check("reset init_done", int'(init_done), 0);
    check("reset resp_valid", int'(resp_valid), 0);
    check("reset resp_way", int'(resp_way), 0);
    check("reset req_ready", int'(req_ready), 0);
    check("reset wren", int'(ram_wren), 0);

    sweep_check("init");

    foreach (vecs[i]) vec_apply(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back victims to index 3 rely on RAM collision forwarding.
    next_cycle(); set_req(1, 1, 3, 0); mid();
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      set_req(k < 2, 1, 3, 0);
      mid();
      check($sformatf("b2b resp_valid %0d", k), int'(resp_valid), 1);
      check($sformatf("b2b resp_way %0d", k), int'(resp_way), k);
      check($sformatf("b2b data %0d", k), int'(ram_data), k + 1);
    end

    // Reset while a victim to index 9 (pointer 4) sits in stage 1.
    check("idx9 pointer before reset", int'(mem[9]), 4);
    next_cycle(); set_req(1, 1, 9, 0); mid();
    next_cycle(); set_req(0, 0, 0, 0); aclr = 1'b1; mid();
    check("midreset resp_valid", int'(resp_valid), 0);
    check("midreset wren", int'(ram_wren), 0);
    sweep_check("midreset");
    vec_apply('{1, 9, 0, 1, 0, 1, 1}, "after midreset");

    // Interleaved victims 1,2,1 from a fresh init.
    reset_and_init("interleave");
    next_cycle(); set_req(1, 1, 1, 0); mid();
    next_cycle(); set_req(1, 1, 2, 0); mid();
    check("il resp1 way", int'(resp_way), 0);
    check("il resp1 addr", int'(ram_wraddress), 1);
    next_cycle(); set_req(1, 1, 1, 0); mid();
    check("il resp2 way", int'(resp_way), 0);
    check("il resp2 addr", int'(ram_wraddress), 2);
    next_cycle(); set_req(0, 0, 0, 0); mid();
    check("il resp3 valid", int'(resp_valid), 1);
    check("il resp3 way", int'(resp_way), 1);
    next_cycle(); mid();
    check("il resp_valid idle", int'(resp_valid), 0);
    check("il final ptr idx1", int'(mem[1]), 2);
    check("il final ptr idx2", int'(mem[2]), 1);

    // Random traffic against a sequential pointer model.
    reset_and_init("random");
    begin
      bit p_rv = 0, p_wren = 0;
      int p_way = 0, p_addr = 0, p_data = 0;
      for (int k = 0; k <= 600; k++) begin
        bit v, op;
        int idx, way;
        v   = (k < 600) && ($urandom_range(0, 9) < 7);
        op  = 1'($urandom_range(0, 1));
        idx = $urandom_range(0, 3);
        way = $urandom_range(0, 7);
        if ($urandom_range(0, 1) == 1) way = model_ptr[idx];
        next_cycle();
        set_req(v, op, idx, way);
        mid();
        check($sformatf("rnd%0d resp_valid", k), int'(resp_valid), int'(p_rv));
        if (p_rv) check($sformatf("rnd%0d resp_way", k), int'(resp_way), p_way);
        check($sformatf("rnd%0d wren", k), int'(ram_wren), int'(p_wren));
        if (p_wren) begin
          check($sformatf("rnd%0d wraddress", k), int'(ram_wraddress), p_addr);
          check($sformatf("rnd%0d data", k), int'(ram_data), p_data);
        end
        p_rv = 0;
        p_wren = 0;
        if (v) begin
          int p;
          p = model_ptr[idx];
          if (op) begin
            p_rv  = 1;
            p_way = p;
          end
          if (op || way == p) begin
            model_ptr[idx] = (p + 1) % 8;
            p_wren = 1;
            p_addr = idx;
            p_data = model_ptr[idx];
          end
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
